// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous instruction ROM
// (one-cycle read latency) and presents {instr, pc, valid} to decode.
// Execute-stage jumps redirect fetch, and the hazard unit can hold fetch.
// A halt encoding stops fetch until the next reset.
module fetch_stage #(
    parameter int unsigned                ADDR_WIDTH  = 32,
    parameter int unsigned                INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0,
    parameter int unsigned                PC_INCR     = 4,
    parameter logic [INSTR_WIDTH-1:0]     HALT_INSTR  = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_f,
    input  logic                   JumpI_e,
    input  logic                   JumpCI_e,
    input  logic                   JumpCD_e,
    input  logic                   zero_e,
    input  logic [ADDR_WIDTH-1:0]  target_e,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_d,
    output logic [ADDR_WIDTH-1:0]  pc_d,
    output logic [ADDR_WIDTH-1:0]  pc_plus_d,
    output logic                   valid_d,
    output logic                   flush_e,
    output logic                   halted,
    output logic [31:0]            instr_count
);

    localparam logic [ADDR_WIDTH-1:0] INCR = ADDR_WIDTH'(PC_INCR);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   pcNext;
    logic [31:0]             count_q;
    logic                    takenBranch;
    logic                    acceptInstr;
    logic                    haltHit;

    // Branch resolution from execute and the decode-acceptance condition.
    // A halt is only recognised on an instruction that decode really accepts,
    // so a wrong-path or stalled halt never stops fetch.
    always_comb begin
        takenBranch = JumpI_e | (JumpCI_e & zero_e) | (JumpCD_e & ~zero_e);
        acceptInstr = (state_q == RUN) & ~stall_f & ~takenBranch;
        haltHit     = acceptInstr & (imem_rdata == HALT_INSTR);
    end

    // Next fetch address; the ROM is addressed with it so that the data
    // returned next cycle always belongs to pc_q. The PC is also held on the
    // halting cycle so that it stays parked on the halt instruction.
    always_comb begin
        pcNext = pc_q + INCR;
        if (rst) begin
            pcNext = RESET_PC;
        end else if (state_q == FILL || state_q == HALTED) begin
            pcNext = pc_q;
        end else if (takenBranch) begin
            pcNext = target_e;
        end else if (stall_f || haltHit) begin
            pcNext = pc_q;
        end
    end

    // State register for the fetch FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one fill cycle, then run until a halt is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    state_d = RUN;
            RUN:     if (haltHit) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = FILL;
        endcase
    end

    // FSM outputs; flush is suppressed outside RUN and while in reset.
    always_comb begin
        valid_d = 1'b0;
        halted  = 1'b0;
        flush_e = 1'b0;
        case (state_q)
            RUN: begin
                valid_d = 1'b1;
                flush_e = takenBranch & ~rst;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // PC register follows the fetch address every edge.
    always_ff @(posedge clk) begin
        pc_q <= pcNext;
    end

    // Count of instructions decode accepted; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (acceptInstr) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign imem_addr   = pcNext;
    assign instr_d     = imem_rdata;
    assign pc_d        = pc_q;
    assign pc_plus_d   = pc_q + INCR;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven vectors whose expected
// outputs are queued when each vector is driven and popped when sampled.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        jI;
        logic        jCI;
        logic        jCD;
        logic        zero;
        logic [31:0] target;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic        expValid;
        logic        expFlush;
        logic        expHalted;
        logic [31:0] expCount;
        logic [31:0] expAddr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        JumpI_e;
    logic        JumpCI_e;
    logic        JumpCD_e;
    logic        zero_e;
    logic [31:0] target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus_d;
    logic        valid_d;
    logic        flush_e;
    logic        halted;
    logic [31:0] instr_count;

    logic [31:0] rom [0:255];
    vec_t        vecTable[$];
    vec_t        expQ[$];
    int          checks   = 0;
    int          failures = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .JumpI_e     (JumpI_e),
        .JumpCI_e    (JumpCI_e),
        .JumpCD_e    (JumpCD_e),
        .zero_e      (zero_e),
        .target_e    (target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus_d   (pc_plus_d),
        .valid_d     (valid_d),
        .flush_e     (flush_e),
        .halted      (halted),
        .instr_count (instr_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous word-addressed instruction ROM with one-cycle latency.
    always @(posedge clk) begin
        imem_rdata <= rom[imem_addr[9:2]];
    end

    function automatic vec_t mkVec(
        input logic rstV, input logic st, input logic ji, input logic jci,
        input logic jcd, input logic z, input logic [31:0] tgt,
        input logic [31:0] pc, input logic [31:0] ins, input logic v,
        input logic f, input logic h, input logic [31:0] cnt,
        input logic [31:0] addr);
        vec_t r;
        r.rst = rstV; r.stall = st; r.jI = ji; r.jCI = jci; r.jCD = jcd;
        r.zero = z; r.target = tgt; r.expPc = pc; r.expInstr = ins;
        r.expValid = v; r.expFlush = f; r.expHalted = h; r.expCount = cnt;
        r.expAddr = addr;
        return r;
    endfunction

    task automatic compare(input string name, input int row,
                           input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // Drive one vector just after the rising edge and queue its expectation.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst      = v.rst;
        stall_f  = v.stall;
        JumpI_e  = v.jI;
        JumpCI_e = v.jCI;
        JumpCD_e = v.jCD;
        zero_e   = v.zero;
        target_e = v.target;
        expQ.push_back(v);
    endtask

    // Sample mid-cycle and compare against the oldest queued expectation.
    task automatic checkOutput(input int row);
        vec_t e;
        #3;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard row %0d: got empty queue expected entry", row);
        end else begin
            e = expQ.pop_front();
            compare("pc_d",        row, pc_d,              e.expPc);
            compare("pc_plus_d",   row, pc_plus_d,         e.expPc + 32'd4);
            compare("instr_d",     row, instr_d,           e.expInstr);
            compare("valid_d",     row, {31'd0, valid_d},  {31'd0, e.expValid});
            compare("flush_e",     row, {31'd0, flush_e},  {31'd0, e.expFlush});
            compare("halted",      row, {31'd0, halted},   {31'd0, e.expHalted});
            compare("instr_count", row, instr_count,       e.expCount);
            compare("imem_addr",   row, imem_addr,         e.expAddr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'(i);

        // First reset cycle with a jump pending: address pinned, no flush.
        rst = 1'b1; stall_f = 1'b0; JumpI_e = 1'b1; JumpCI_e = 1'b0;
        JumpCD_e = 1'b0; zero_e = 1'b0; target_e = 32'h40;
        #4;
        compare("reset imem_addr", -1, imem_addr, 32'h0);
        compare("reset flush_e",   -1, {31'd0, flush_e}, 32'h0);

        // Fill, free run, stall, branches, wrap and reset mid-branch.
        //                   rst st jI jCI jCD z  target        pc            instr v  f  h  cnt addr
        vecTable.push_back(mkVec(1, 0, 1, 0, 0, 0, 32'h40,       32'h0,        0,   0, 0, 0, 0, 32'h0));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   0, 0, 0, 0, 32'h0));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 32'h4));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h4,        1,   1, 0, 0, 1, 32'h8));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h8,        2,   1, 0, 0, 2, 32'hC));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'h8,        32'hC,        3,   1, 1, 0, 3, 32'h8));
        vecTable.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0,        32'h8,        2,   1, 0, 0, 3, 32'h8));
        vecTable.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0,        32'h8,        2,   1, 0, 0, 3, 32'h8));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h8,        2,   1, 0, 0, 3, 32'hC));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'hC,        3,   1, 0, 0, 4, 32'h10));
        vecTable.push_back(mkVec(0, 0, 0, 1, 0, 1, 32'h40,       32'h10,       4,   1, 1, 0, 5, 32'h40));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'h10,       32'h40,       16,  1, 1, 0, 5, 32'h10));
        vecTable.push_back(mkVec(0, 0, 0, 1, 0, 0, 32'h40,       32'h10,       4,   1, 0, 0, 5, 32'h14));
        vecTable.push_back(mkVec(0, 1, 1, 0, 0, 0, 32'h80,       32'h14,       5,   1, 1, 0, 6, 32'h80));
        vecTable.push_back(mkVec(0, 0, 0, 0, 1, 0, 32'h20,       32'h80,       32,  1, 1, 0, 6, 32'h20));
        vecTable.push_back(mkVec(0, 0, 0, 0, 1, 1, 32'h60,       32'h20,       8,   1, 0, 0, 6, 32'h24));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h24,       9,   1, 0, 0, 7, 32'h28));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h28,       10,  1, 1, 0, 8, 32'hFFFFFFFC));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 255, 1, 0, 0, 8, 32'h0));
        vecTable.push_back(mkVec(1, 0, 1, 0, 0, 0, 32'h40,       32'h0,        0,   1, 0, 0, 9, 32'h0));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'h40,       32'h0,        0,   0, 0, 0, 0, 32'h0));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0,   1, 0, 0, 0, 32'h4));

        for (int i = 0; i < vecTable.size(); i++) begin
            applyStimulus(vecTable[i]);
            checkOutput(i);
        end

        // Halt sequence: ROM word 3 (byte 0x0C) becomes the halt encoding.
        rom[3] = HALT;
        vecTable.delete();
        //                   rst st jI jCI jCD z  target  pc      instr v  f  h  cnt addr
        vecTable.push_back(mkVec(1, 0, 0, 0, 0, 0, 32'h0,  32'h4,  1,    1, 0, 0, 1, 32'h0));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0,    0, 0, 0, 0, 32'h0));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0,    1, 0, 0, 0, 32'h4));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'h4,  1,    1, 0, 0, 1, 32'h8));
        vecTable.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0,  32'h8,  2,    1, 0, 0, 2, 32'h8));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'h8,  2,    1, 0, 0, 2, 32'hC));
        vecTable.push_back(mkVec(0, 1, 0, 0, 0, 0, 32'h0,  32'hC,  HALT, 1, 0, 0, 3, 32'hC));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'h40, 32'hC,  HALT, 1, 1, 0, 3, 32'h40));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'hC,  32'h40, 16,   1, 1, 0, 3, 32'hC));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'hC,  HALT, 1, 0, 0, 3, 32'hC));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'h40, 32'hC,  HALT, 0, 0, 1, 4, 32'hC));
        vecTable.push_back(mkVec(0, 1, 0, 1, 0, 1, 32'h40, 32'hC,  HALT, 0, 0, 1, 4, 32'hC));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'hC,  HALT, 0, 0, 1, 4, 32'hC));
        vecTable.push_back(mkVec(1, 0, 0, 0, 0, 0, 32'h0,  32'hC,  HALT, 0, 0, 1, 4, 32'h0));
        vecTable.push_back(mkVec(0, 0, 1, 0, 0, 0, 32'h40, 32'h0,  0,    0, 0, 0, 0, 32'h0));
        vecTable.push_back(mkVec(0, 0, 0, 0, 0, 0, 32'h0,  32'h0,  0,    1, 0, 0, 0, 32'h4));

        for (int i = 0; i < vecTable.size(); i++) begin
            applyStimulus(vecTable[i]);
            checkOutput(100 + i);
        end

        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined scalar/vector processor. It sits directly upstream of decode and feeds control_unit's instruction fields.
- Owns the PC and drives a synchronous instruction ROM (1-cycle read latency).
- Presents {instr, pc, valid} to decode.
- Applies branch redirects resolved in execute from JumpI/JumpCI/JumpCD.
- Handles load-use stalls, the post-reset fill cycle and program halt.

Parameters:
ADDR_WIDTH, 32, PC / ROM address width
INSTR_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset
PC_INCR, 4, sequential PC step
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
stall_f  in  1  hazard unit: hold fetch/decode this cycle
JumpI_e  in  1  execute-stage unconditional jump
JumpCI_e  in  1  execute-stage jump-if-equal
JumpCD_e  in  1  execute-stage jump-if-not-equal
zero_e  in  1  execute ALU zero flag
target_e  in  ADDR_WIDTH  execute-computed jump target
imem_addr  out  ADDR_WIDTH  ROM address (combinational, = pc_next)
imem_rdata  in  INSTR_WIDTH  ROM data, valid 1 cycle after address
instr_d  out  INSTR_WIDTH  instruction to decode (= imem_rdata)
pc_d  out  ADDR_WIDTH  address of instr_d
pc_plus_d  out  ADDR_WIDTH  pc_d + PC_INCR
valid_d  out  1  instr_d is a real instruction
flush_e  out  1  squash the decode→execute register this cycle
halted  out  1  fetch stopped on HALT_INSTR
instr_count  out  32  instructions accepted by decode

Behaviour:
- Reset (edge with rst=1): pc_f=RESET_PC, state=FILL, valid_d=0, halted=0, instr_count=0. While rst=1, imem_addr=RESET_PC and flush_e=0.
- Branch decode: taken = JumpI_e | (JumpCI_e & zero_e) | (JumpCD_e & ~zero_e). flush_e = taken & (state==RUN). The cycle is combinational.
- pc_next priority:
  - rst → RESET_PC
  - state FILL or HALTED → pc_f
  - taken → target_e
  - stall_f → pc_f
  - otherwise → pc_f + PC_INCR, with modulo-2^ADDR_WIDTH wrap
- imem_addr = pc_next; pc_f <= pc_next every edge. Result: imem_rdata always corresponds to pc_f.
- pc_d = pc_f; pc_plus_d = pc_f + PC_INCR, wrapping.
- States:
  - FILL: one cycle, valid_d=0, ROM primed at RESET_PC, then → RUN.
  - RUN: valid_d=1.
    - → HALTED when imem_rdata==HALT_INSTR & valid_d & ~stall_f & ~taken. The halt instruction itself is accepted by decode that cycle.
  - HALTED: valid_d=0, halted=1, pc frozen, flush_e=0, branch/stall inputs ignored. Exit only via rst.
- Taken branch: the wrong-path instruction in decode is squashed via flush_e. The next cycle presents mem[target_e] with valid_d=1. Penalty is 1 bubble.
- stall_f & taken in the same cycle: taken wins (PC redirects, flush_e=1).
- HALT_INSTR in decode while taken: no halt, because it is wrong-path.
- HALT_INSTR while stalled: halt deferred until stall_f=0.
- instr_count increments when state==RUN & valid_d & ~stall_f & ~taken. It wraps at 2^32 and is held in HALTED.
- Decode/ID-EX logic gates all register/memory writes with valid_d. instr_d is raw ROM data and is not a NOP when valid_d=0.
- Reset mid-operation (any state, including HALTED, during a stall or a branch): rst overrides everything and the next cycle is FILL.

Test Plan:
- Reset then free-run, ROM[i]=i, no stalls → cycle 1 valid_d=0 (FILL); then pc_d=0,4,8,12 with instr_d=0,1,2,3 and valid_d=1; instr_count=3 after 3 accepted cycles.
- stall_f=1 for 2 cycles at pc_d=8 → pc_d=8, instr_d=ROM[8] held both cycles; instr_count frozen; resumes at 12.
- JumpCI_e=1, zero_e=1, target_e=0x40 while pc_d=0x10 → flush_e=1 that cycle, next pc_d=0x40, valid_d=1. Repeat with zero_e=0 → no flush, pc_d=0x14.
- JumpI_e=1, target_e=0x80 with stall_f=1 simultaneously → flush_e=1, next pc_d=0x80; also JumpCD_e=1, zero_e=0, target=0x20 → taken.
- ROM[0x0C]=HALT_INSTR → halt instruction accepted (count+1), then halted=1, valid_d=0, pc_d frozen at 0x0C; later JumpI_e pulses are ignored.
- rst asserted while halted and again mid-branch → next cycle FILL, pc_d=RESET_PC, instr_count=0, halted=0.
